uart_rx: RTL and testbench

Asynchronous serial receiver that deserialises 8N1 frames arriving on the UART RX line into bytes for the multiplier datapath. It is the receive-side counterpart of the UART transmitter and uses the same `freq_control` baud encoding and bit-period arithmetic, so the two interoperate in loopback. It has a one-deep output holding register with a valid/ack handshake, and reports framing and overrun errors.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud encoding, receiver states and frame width.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      Idle,
      Start_Check,
      Receive_Data,
      Stop_Check
   } rx_state_t;

   function automatic logic [12:0] pulse_of(input logic [1:0] freq_control);
      case (freq_control)
         2'b00:   return 13'd5208;
         2'b01:   return 13'd434;
         2'b10:   return 13'd50;
         default: return 13'd12;
      endcase
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser; both stages come out of reset high (idle line).
`timescale 1ns/1ps
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-deep holding register,
// and single-cycle framing-error / overrun pulses.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
(
   input  logic       uart_clock,
   input  logic       uart_reset,
   input  logic       uart_d_in,
   input  logic [1:0] freq_control,
   input  logic       uart_rx_ack,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx_valid,
   output logic       uart_rx_frame_err,
   output logic       uart_rx_overrun
);

   logic        rx_sync;
   logic        prev_reg;
   logic        start_det_reg;
   rx_state_t   state_reg, state_next;
   logic [12:0] clk_count_reg, clk_count_next;
   logic [2:0]  bit_count_reg, bit_count_next;
   logic [7:0]  shift_data_reg, shift_data_next;
   logic [12:0] pd_lat_reg, pd_lat_next;
   logic [7:0]  data_reg, data_next;
   logic        valid_reg, valid_next;
   logic        frame_err_reg, frame_err_next;
   logic        overrun_reg, overrun_next;
   logic        deliver;
   logic [12:0] half_period;

   sync_2ff u_sync (
      .clk (uart_clock),
      .rst (uart_reset),
      .d   (uart_d_in),
      .q   (rx_sync)
   );

   assign half_period = pd_lat_reg >> 1;

   // Edge detect is registered, so Start_Check begins three edges after the
   // synchroniser first samples the line low.
   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         prev_reg      <= 1'b1;
         start_det_reg <= 1'b0;
      end else begin
         prev_reg      <= rx_sync;
         start_det_reg <= prev_reg & ~rx_sync;
      end
   end

   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         state_reg      <= Idle;
         clk_count_reg  <= '0;
         bit_count_reg  <= '0;
         shift_data_reg <= '0;
         pd_lat_reg     <= '0;
         data_reg       <= '0;
         valid_reg      <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         clk_count_reg  <= clk_count_next;
         bit_count_reg  <= bit_count_next;
         shift_data_reg <= shift_data_next;
         pd_lat_reg     <= pd_lat_next;
         data_reg       <= data_next;
         valid_reg      <= valid_next;
         frame_err_reg  <= frame_err_next;
         overrun_reg    <= overrun_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      clk_count_next  = clk_count_reg;
      bit_count_next  = bit_count_reg;
      shift_data_next = shift_data_reg;
      pd_lat_next     = pd_lat_reg;
      data_next       = data_reg;
      valid_next      = valid_reg;
      frame_err_next  = 1'b0;
      overrun_next    = 1'b0;
      deliver         = 1'b0;

      case (state_reg)
         Idle: begin
            if (start_det_reg) begin
               state_next     = Start_Check;
               clk_count_next = '0;
               pd_lat_next    = pulse_of(freq_control);
            end
         end
         Start_Check: begin
            clk_count_next = clk_count_reg + 13'd1;
            if (clk_count_reg == half_period) begin
               clk_count_next = '0;
               bit_count_next = '0;
               // A line that is high again at mid-start was only a glitch.
               state_next     = rx_sync ? Idle : Receive_Data;
            end
         end
         Receive_Data: begin
            clk_count_next = clk_count_reg + 13'd1;
            if (clk_count_reg == pd_lat_reg) begin
               shift_data_next = {rx_sync, shift_data_reg[7:1]};
               clk_count_next  = '0;
               bit_count_next  = bit_count_reg + 3'd1;
               if (bit_count_reg == 3'(DATA_BITS - 1))
                  state_next = Stop_Check;
            end
         end
         Stop_Check: begin
            clk_count_next = clk_count_reg + 13'd1;
            if (clk_count_reg == pd_lat_reg) begin
               clk_count_next = '0;
               state_next     = Idle;
               deliver        = rx_sync;
               frame_err_next = ~rx_sync;
            end
         end
         default: state_next = Idle;
      endcase

      // A same-cycle ack frees the holding register for the incoming byte.
      if (deliver) begin
         if (!valid_reg || uart_rx_ack) begin
            data_next  = shift_data_reg;
            valid_next = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end else if (valid_reg && uart_rx_ack) begin
         valid_next = 1'b0;
      end
   end

   assign uart_rx_data      = data_reg;
   assign uart_rx_valid     = valid_reg;
   assign uart_rx_frame_err = frame_err_reg;
   assign uart_rx_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame stimulus for uart_rx, checked each cycle against a
// frame-level model plus hand-computed anchor expectations.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       uart_clock   = 1'b0;
   logic       uart_reset   = 1'b1;
   logic       uart_d_in    = 1'b1;
   logic [1:0] freq_control = 2'b11;
   logic       uart_rx_ack  = 1'b0;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_frame_err;
   logic       uart_rx_overrun;

   always #5 uart_clock = ~uart_clock;

   uart_rx dut (
      .uart_clock        (uart_clock),
      .uart_reset        (uart_reset),
      .uart_d_in         (uart_d_in),
      .freq_control      (freq_control),
      .uart_rx_ack       (uart_rx_ack),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_overrun   (uart_rx_overrun)
   );

   // Planned frames: outcome edge = edge0 + 4 + H + 9P.
   int unsigned plan_at   [512];
   logic [7:0]  plan_b    [512];
   logic        plan_stop [512];
   int          wr_idx = 0;
   int          rd_idx = 0;

   int unsigned lit_edge [64];
   int          lit_kind [64];
   logic [31:0] lit_val  [64];
   string       lit_name [64];
   int          lit_n  = 0;
   int          lit_rd = 0;

   int unsigned edge_cnt = 0;
   logic [7:0]  m_data  = 8'h00;
   logic        m_valid = 1'b0;
   logic        m_fe    = 1'b0;
   logic        m_ov    = 1'b0;
   int          total = 0;
   int          bad   = 0;
   int          fe_seen = 0;
   int          ov_seen = 0;
   bit          ack_auto = 1'b0;

   function automatic int unsigned pd_of(input logic [1:0] f);
      case (f)
         2'b00:   return 5208;
         2'b01:   return 434;
         2'b10:   return 50;
         default: return 12;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_cnt, got, want);
      end
   endtask

   // Model steps on each rising edge; DUT is compared on the falling edge.
   always begin
      @(posedge uart_clock);
      edge_cnt++;
      if (uart_reset) begin
         m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
         rd_idx = wr_idx;
      end else begin
         m_fe = 1'b0;
         m_ov = 1'b0;
         if (rd_idx < wr_idx && plan_at[rd_idx] == edge_cnt) begin
            $display("frame byte=%02h stop=%0d edge=%0d", plan_b[rd_idx], plan_stop[rd_idx], edge_cnt);
            if (!plan_stop[rd_idx]) m_fe = 1'b1;
            else if (!m_valid || uart_rx_ack) begin
               m_data  = plan_b[rd_idx];
               m_valid = 1'b1;
            end else m_ov = 1'b1;
            rd_idx++;
         end else if (m_valid && uart_rx_ack) begin
            m_valid = 1'b0;
         end
      end
      @(negedge uart_clock);
      chk("data",      32'(uart_rx_data),      uart_reset ? 32'd0 : 32'(m_data));
      chk("valid",     32'(uart_rx_valid),     uart_reset ? 32'd0 : 32'(m_valid));
      chk("frame_err", 32'(uart_rx_frame_err), uart_reset ? 32'd0 : 32'(m_fe));
      chk("overrun",   32'(uart_rx_overrun),   uart_reset ? 32'd0 : 32'(m_ov));
      if (uart_rx_frame_err === 1'b1) fe_seen++;
      if (uart_rx_overrun === 1'b1) ov_seen++;
      while (lit_rd < lit_n && lit_edge[lit_rd] <= edge_cnt) begin
         if (lit_edge[lit_rd] < edge_cnt) begin
            total++;
            bad++;
            $display("FAIL %s missed edge=%0d now=%0d", lit_name[lit_rd], lit_edge[lit_rd], edge_cnt);
         end else begin
            case (lit_kind[lit_rd])
               0:       chk(lit_name[lit_rd], {23'd0, uart_rx_valid, uart_rx_data}, lit_val[lit_rd]);
               1:       chk(lit_name[lit_rd], 32'(fe_seen), lit_val[lit_rd]);
               default: chk(lit_name[lit_rd], 32'(ov_seen), lit_val[lit_rd]);
            endcase
         end
         lit_rd++;
      end
   end

   task automatic tick();
      @(posedge uart_clock);
      #1;
      if (ack_auto) uart_rx_ack = ($urandom_range(0, 3) == 0);
   endtask

   task automatic expect_at(input int unsigned e, input int k, input logic [31:0] v, input string n);
      lit_edge[lit_n] = e;
      lit_kind[lit_n] = k;
      lit_val[lit_n]  = v;
      lit_name[lit_n] = n;
      lit_n++;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      int unsigned p, h;
      p = pd_of(freq_control) + 1;
      h = pd_of(freq_control) >> 1;
      plan_at[wr_idx]   = edge_cnt + 1 + 4 + h + 9 * p;
      plan_b[wr_idx]    = b;
      plan_stop[wr_idx] = stop;
      wr_idx++;
      uart_d_in = 1'b0;
      repeat (p) tick();
      for (int i = 0; i < 8; i++) begin
         uart_d_in = b[i];
         repeat (p) tick();
      end
      uart_d_in = stop;
      repeat (p) tick();
      uart_d_in = 1'b1;
   endtask

   int unsigned base;
   int unsigned deliv;
   logic [7:0]  part_b;

   initial begin
      repeat (3) tick();
      uart_reset = 1'b0;
      expect_at(edge_cnt + 1, 0, 32'h000, "reset_state");
      repeat (3) tick();

      // Nominal 0xA5 at P=13: valid rises 127 edges after edge 0.
      base = edge_cnt + 1;
      expect_at(base + 126, 0, 32'h000, "nominal_before");
      expect_at(base + 127, 0, 32'h1A5, "nominal_valid");
      send(8'hA5, 1'b1);
      uart_rx_ack = 1'b1;
      expect_at(edge_cnt + 1, 0, 32'h0A5, "ack_clears");
      tick();
      uart_rx_ack = 1'b0;
      tick();
      uart_rx_ack = 1'b1;
      tick();
      uart_rx_ack = 1'b0;
      repeat (5) tick();

      // Stop bit forced low.
      base = edge_cnt + 1;
      expect_at(base + 127, 0, 32'h0A5, "fe_no_valid");
      send(8'h81, 1'b0);
      expect_at(edge_cnt, 1, 32'd1, "frame_err_count");
      repeat (20) tick();

      // Three-clock glitch on idle line.
      uart_d_in = 1'b0;
      repeat (3) tick();
      uart_d_in = 1'b1;
      repeat (40) tick();
      expect_at(edge_cnt, 1, 32'd1, "glitch_no_err");
      expect_at(edge_cnt, 0, 32'h0A5, "glitch_no_valid");

      // Back-to-back without ack: second byte dropped.
      send(8'h12, 1'b1);
      send(8'h34, 1'b1);
      expect_at(edge_cnt, 2, 32'd1, "overrun_count");
      expect_at(edge_cnt, 0, 32'h112, "overrun_keeps_old");
      uart_rx_ack = 1'b1;
      tick();
      uart_rx_ack = 1'b0;
      repeat (5) tick();

      // Same again, with ack in the delivery cycle of the second byte.
      base  = edge_cnt + 1;
      deliv = base + 130 + 127;
      expect_at(deliv, 0, 32'h134, "ack_on_delivery");
      fork
         begin
            send(8'h12, 1'b1);
            send(8'h34, 1'b1);
         end
         begin
            while (edge_cnt < deliv - 1) tick();
            uart_rx_ack = 1'b1;
            tick();
            uart_rx_ack = 1'b0;
         end
      join
      expect_at(edge_cnt, 2, 32'd1, "no_new_overrun");
      repeat (5) tick();

      // Reset during data bit 4 while a byte is still held.
      part_b = 8'hC3;
      uart_d_in = 1'b0;
      repeat (13) tick();
      for (int i = 0; i < 5; i++) begin
         uart_d_in = part_b[i];
         repeat ((i == 4) ? 6 : 13) tick();
      end
      uart_reset = 1'b1;
      uart_d_in  = 1'b1;
      expect_at(edge_cnt, 0, 32'h000, "reset_mid_frame");
      repeat (3) tick();
      uart_reset = 1'b0;
      repeat (20) tick();
      base = edge_cnt + 1;
      expect_at(base + 127, 0, 32'h13C, "after_reset");
      send(8'h3C, 1'b1);
      uart_rx_ack = 1'b1;
      tick();
      uart_rx_ack = 1'b0;
      repeat (5) tick();

      // Baud select changes mid-frame; current frame stays at P=13.
      base = edge_cnt + 1;
      expect_at(base + 127, 0, 32'h1C6, "baud_change_mid");
      fork
         send(8'hC6, 1'b1);
         begin
            repeat (40) tick();
            freq_control = 2'b10;
         end
      join
      uart_rx_ack = 1'b1;
      tick();
      uart_rx_ack = 1'b0;
      repeat (5) tick();

      // Loopback at the three faster rates with a random consumer.
      ack_auto = 1'b1;
      for (int f = 1; f < 4; f++) begin
         freq_control = 2'(f);
         send(8'h00, 1'b1);
         send(8'hFF, 1'b1);
         send(8'h55, 1'b1);
         for (int n = 0; n < ((f == 1) ? 0 : (f == 2) ? 17 : 100); n++)
            send(8'($urandom_range(0, 255)), 1'b1);
      end
      ack_auto = 1'b0;
      uart_rx_ack = 1'b0;
      repeat (20) tick();
      expect_at(edge_cnt, 1, 32'd1, "loopback_no_fe");
      expect_at(edge_cnt, 2, 32'd1, "loopback_no_ov");
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
